// File: rtl/module_quant_array.sv
// N-lane requantiser: out = clamp(round((acc*scale) >> shift) + zero_point, 0, 2^OUT_W-1).
// Three-stage pipe with a global stall; every beat carries its own copy of the config.
module module_quant_array #(
  parameter int LANES   = 8,
  parameter int ACC_W   = 15,
  parameter int SCALE_W = 16,
  parameter int SHIFT_W = 4,
  parameter int OUT_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [SCALE_W-1:0]       cfg_scale,
  input  logic [SHIFT_W-1:0]       cfg_shift,
  input  logic [OUT_W-1:0]         cfg_zero_point,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*ACC_W-1:0]   in_acc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*OUT_W-1:0]   out_q,
  output logic                     busy
);

  localparam int PROD_W = ACC_W + SCALE_W;
  localparam int RND_W  = PROD_W + 1;
  localparam int SUM_W  = RND_W + 1;
  localparam logic signed [SUM_W-1:0] MAX_Q = SUM_W'((1 << OUT_W) - 1);

  logic signed [SCALE_W-1:0] scale_q, scale_d;
  logic [SHIFT_W-1:0]        shift_q, shift_d;
  logic [OUT_W-1:0]          zp_q, zp_d;

  logic                      v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [PROD_W-1:0]  prod1_q [LANES];
  logic signed [PROD_W-1:0]  prod1_d [LANES];
  logic [SHIFT_W-1:0]        shift1_q, shift1_d;
  logic [OUT_W-1:0]          zp1_q, zp1_d, zp2_q, zp2_d;
  logic signed [RND_W-1:0]   sh2_q [LANES];
  logic signed [RND_W-1:0]   sh2_d [LANES];
  logic [LANES*OUT_W-1:0]    out_q_q, out_q_d;

  logic                      advance;
  logic signed [PROD_W-1:0]  prod_c [LANES];
  logic signed [RND_W-1:0]   rnd_inc;
  logic signed [RND_W-1:0]   rnd_c [LANES];
  logic signed [RND_W-1:0]   sh_c [LANES];
  logic signed [SUM_W-1:0]   sum_c [LANES];
  logic [OUT_W-1:0]          clamp_c [LANES];

  assign advance   = !v3_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = v3_q;
  assign out_q     = out_q_q;
  assign busy      = v1_q || v2_q || v3_q;

  // Per-lane arithmetic for all three stages; widths chosen so nothing can overflow.
  always_comb begin
    rnd_inc = '0;
    if (shift1_q != '0) rnd_inc[shift1_q - 1'b1] = 1'b1;
    for (int unsigned i = 0; i < LANES; i++) begin
      prod_c[i] = PROD_W'($signed(in_acc[i*ACC_W +: ACC_W])) * PROD_W'(scale_q);
      rnd_c[i]  = RND_W'(prod1_q[i]) + rnd_inc;
      sh_c[i]   = rnd_c[i] >>> shift1_q;
      sum_c[i]  = SUM_W'(sh2_q[i]) + SUM_W'($signed({1'b0, zp2_q}));
      if (sum_c[i][SUM_W-1])  clamp_c[i] = '0;
      else if (sum_c[i] > MAX_Q) clamp_c[i] = '1;
      else                    clamp_c[i] = sum_c[i][OUT_W-1:0];
    end
  end

  always_comb begin
    scale_d  = scale_q;
    shift_d  = shift_q;
    zp_d     = zp_q;
    v1_d     = v1_q;
    v2_d     = v2_q;
    v3_d     = v3_q;
    prod1_d  = prod1_q;
    shift1_d = shift1_q;
    zp1_d    = zp1_q;
    sh2_d    = sh2_q;
    zp2_d    = zp2_q;
    out_q_d  = out_q_q;
    if (cfg_we) begin
      scale_d = cfg_scale;
      shift_d = cfg_shift;
      zp_d    = cfg_zero_point;
    end
    // S1 samples the pre-write config, so a beat accepted alongside cfg_we sees the old values.
    if (advance) begin
      v1_d     = in_valid;
      prod1_d  = prod_c;
      shift1_d = shift_q;
      zp1_d    = zp_q;
      v2_d     = v1_q;
      sh2_d    = sh_c;
      zp2_d    = zp1_q;
      v3_d     = v2_q;
      for (int unsigned i = 0; i < LANES; i++) out_q_d[i*OUT_W +: OUT_W] = clamp_c[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scale_q  <= '0;
      shift_q  <= '0;
      zp_q     <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      shift1_q <= '0;
      zp1_q    <= '0;
      zp2_q    <= '0;
      out_q_q  <= '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        prod1_q[i] <= '0;
        sh2_q[i]   <= '0;
      end
    end else begin
      scale_q  <= scale_d;
      shift_q  <= shift_d;
      zp_q     <= zp_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      prod1_q  <= prod1_d;
      shift1_q <= shift1_d;
      zp1_q    <= zp1_d;
      sh2_q    <= sh2_d;
      zp2_q    <= zp2_d;
      out_q_q  <= out_q_d;
    end
  end

endmodule

// File: tb/tb_module_quant_array.sv
// Directed bench for module_quant_array with hand-computed expected lanes.
module tb_module_quant_array;

  localparam int LANES = 8;
  localparam int ACC_W = 15;
  localparam int OUT_W = 4;

  logic                   clk = 1'b0;
  logic                   rst, cfg_we, in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0]            cfg_scale;
  logic [3:0]             cfg_shift, cfg_zero_point;
  logic [LANES*ACC_W-1:0] in_acc;
  logic [LANES*OUT_W-1:0] out_q;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  module_quant_array #(.LANES(LANES), .ACC_W(ACC_W), .SCALE_W(16), .SHIFT_W(4), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_scale(cfg_scale), .cfg_shift(cfg_shift),
    .cfg_zero_point(cfg_zero_point), .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LANES*ACC_W-1:0] pa(input int a0, a1, a2, a3, a4, a5, a6, a7);
    int a [8];
    logic [LANES*ACC_W-1:0] v;
    a = '{a0, a1, a2, a3, a4, a5, a6, a7};
    for (int i = 0; i < 8; i++) v[i*ACC_W +: ACC_W] = 15'(a[i]);
    return v;
  endfunction

  function automatic logic [LANES*OUT_W-1:0] po(input int e0, e1, e2, e3, e4, e5, e6, e7);
    int e [8];
    logic [LANES*OUT_W-1:0] v;
    e = '{e0, e1, e2, e3, e4, e5, e6, e7};
    for (int i = 0; i < 8; i++) v[i*OUT_W +: OUT_W] = 4'(e[i]);
    return v;
  endfunction

  // With scale=1, shift=0, zp=0 each lane passes 0..15 straight through.
  function automatic int lane_val(input int k, input int i);
    return (3 * k + i) % 16;
  endfunction

  task automatic set_cfg(input int scale, input int shift, input int zp);
    cfg_scale = 16'(scale);
    cfg_shift = 4'(shift);
    cfg_zero_point = 4'(zp);
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic run_beat(input string tag, input logic [LANES*ACC_W-1:0] acc,
                          output logic [LANES*OUT_W-1:0] q);
    int n = 0;
    in_acc = acc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, out_valid, 1);
    q = out_q;
    tick();
  endtask

  logic [LANES*OUT_W-1:0] q, held_q;
  logic [LANES*OUT_W-1:0] res [3];
  logic [LANES*ACC_W-1:0] acc_k;
  logic [LANES*OUT_W-1:0] exp_k;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_scale = '0; cfg_shift = '0; cfg_zero_point = '0;
    in_valid = 1'b0; in_acc = '0; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_q", out_q, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    // Basic rounding/clamp and the 3-register latency
    set_cfg(3, 4, 3);
    in_acc = pa(20, -20, 100, 0, 0, 0, 0, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t1_lat1", out_valid, 0);
    tick();
    check("t1_lat2", out_valid, 0);
    check("t1_busy", busy, 1);
    tick();
    check("t1_valid", out_valid, 1);
    check("t1_q", out_q, po(7, 0, 15, 3, 3, 3, 3, 3));
    tick();
    check("t1_drain", out_valid, 0);

    set_cfg(1, 4, 0);
    run_beat("t2", pa(8, 7, -8, 24, -9, 40, 0, 0), q);
    check("t2_q", q, po(1, 0, 0, 2, 0, 3, 0, 0));

    set_cfg(1, 0, 0);
    run_beat("t3a", pa(5, -1, 16, 15, 0, 0, 0, 0), q);
    check("t3a_q", q, po(5, 0, 15, 15, 0, 0, 0, 0));

    set_cfg(-32768, 15, 3);
    run_beat("t3b", pa(-16384, 16383, 0, -16384, -16384, -16384, -16384, -16384), q);
    check("t3b_q", q, po(15, 0, 3, 15, 15, 15, 15, 15));

    // 10 back-to-back beats with out_ready low in cycles 4..6
    set_cfg(1, 0, 0);
    begin
      int sent = 0, got = 0;
      logic held = 1'b0;
      for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
        out_ready = !(cyc >= 4 && cyc <= 6);
        in_valid = (sent < 10);
        for (int i = 0; i < LANES; i++) acc_k[i*ACC_W +: ACC_W] = 15'(lane_val(sent, i));
        in_acc = acc_k;
        #1;
        if (!out_ready && out_valid) check("t4_in_ready_stall", in_ready, 0);
        if (held) check("t4_hold", out_q, held_q);
        if (out_valid && out_ready) begin
          for (int i = 0; i < LANES; i++) exp_k[i*OUT_W +: OUT_W] = 4'(lane_val(got, i));
          check("t4_order", out_q, exp_k);
          got++;
        end
        held = out_valid && !out_ready;
        held_q = out_q;
        if (in_valid && in_ready) sent++;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("t4_count", got, 10);
      check("t4_nodup", out_valid, 0);
      check("t4_idle", busy, 0);
    end

    // Config write coinciding with beat A; P already in flight, B follows
    set_cfg(3, 4, 3);
    in_acc = pa(20, 20, 20, 20, 20, 20, 20, 20);
    in_valid = 1'b1;
    tick();
    cfg_zero_point = 4'd5;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    tick();
    in_valid = 1'b0;
    cfg_zero_point = 4'd0;
    cfg_we = 1'b1;
    begin
      int n = 0, cyc = 0;
      for (int i = 0; i < 3; i++) res[i] = '0;
      while (n < 3 && cyc < 10) begin
        if (out_valid) begin
          res[n] = out_q;
          n++;
        end
        tick();
        cfg_we = 1'b0;
        cyc++;
      end
      check("t5_count", n, 3);
    end
    check("t5_p", res[0], po(7, 7, 7, 7, 7, 7, 7, 7));
    check("t5_a", res[1], po(7, 7, 7, 7, 7, 7, 7, 7));
    check("t5_b", res[2], po(9, 9, 9, 9, 9, 9, 9, 9));

    // Reset with three beats in flight
    set_cfg(3, 4, 3);
    in_acc = pa(20, 20, 20, 20, 20, 20, 20, 20);
    in_valid = 1'b1;
    out_ready = 1'b0;
    repeat (3) tick();
    in_valid = 1'b0;
    check("t6_busy_pre", busy, 1);
    rst = 1'b1;
    tick();
    check("t6_out_valid", out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_out_q", out_q, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_nostale", out_valid, 0);
    end
    run_beat("t6_cfg", pa(20, 20, 20, 20, 20, 20, 20, 20), q);
    check("t6_cfg_zero", q, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
